// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pool modes, FSM states and saturation helper for the conv/pool back end
package cnn_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clamps a sign-extended value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pool_acc_unit.sv
// rtl/pool_acc_unit.sv - one kernel's 2x2 pool accumulator, max or average
module pool_acc_unit #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic          mode,
  input  logic [DW-1:0] val,
  output logic [DW-1:0] result
);
  import cnn_pkg::*;

  logic signed [DW+1:0] acc_q, acc_d, val_x;

  always_comb begin
    val_x = {{2{val[DW-1]}}, val};
    acc_d = acc_q;
    if (en) begin
      if (load)                  acc_d = val_x;
      else if (mode == POOL_AVG) acc_d = acc_q + val_x;
      else if (val_x > acc_q)    acc_d = val_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Average of four window values is the two-bit right shift of the sum.
  assign result = (mode == POOL_AVG) ? acc_q[DW+1:2] : acc_q[DW-1:0];

endmodule

// File: rtl/conv_pool_out_stage.sv
// rtl/conv_pool_out_stage.sv - channel sum + bias, saturate, ReLU, 2x2 pool and addressed output drain
module conv_pool_out_stage #(
  parameter int IN_CH      = 6,
  parameter int OUT_CH     = 16,
  parameter int DW         = 16,
  parameter int OUT_PIXELS = 25,
  parameter int MAP_SIZE   = 25,
  parameter int ADDR_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       pool_mode,
  input  logic [ADDR_W-1:0]          out_base,
  input  logic                       bias_we,
  input  logic [$clog2(OUT_CH)-1:0]  bias_addr,
  input  logic [DW-1:0]              bias_wdata,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_CH*DW-1:0]        in_data,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DW-1:0]              wr_data,
  output logic                       busy,
  output logic                       done
);
  import cnn_pkg::*;

  localparam int SW = DW + $clog2(IN_CH + 1);
  localparam int KW = $clog2(OUT_CH);
  localparam int PW = $clog2(OUT_PIXELS);
  localparam logic [KW-1:0] K_LAST = KW'(OUT_CH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(OUT_PIXELS - 1);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [KW-1:0]        kern_q, kern_d;
  logic [1:0]           pos_q, pos_d;
  logic [PW-1:0]        pix_q, pix_d;
  logic signed [DW-1:0] bias_q [OUT_CH];
  logic signed [DW-1:0] bias_d [OUT_CH];
  logic                 s1_valid_q, s1_valid_d;
  logic signed [SW-1:0] s1_sum_q, s1_sum_d;
  logic [KW-1:0]        s1_kern_q, s1_kern_d;
  logic [1:0]           s1_pos_q, s1_pos_d;
  logic [PW-1:0]        s1_pix_q, s1_pix_d;
  logic                 win_done_q, win_done_d;
  logic [PW-1:0]        win_pix_q, win_pix_d;
  logic                 bank_full_q, bank_full_d;
  logic [PW-1:0]        bank_pix_q, bank_pix_d;
  logic [KW-1:0]        drain_q, drain_d;
  logic [DW-1:0]        bank_q [OUT_CH];
  logic [DW-1:0]        bank_d [OUT_CH];
  logic [DW-1:0]        pool_res [OUT_CH];
  logic [DW-1:0]        sat_val, relu_val;
  logic                 accept, last_drain;

  // Hold off the closing window beat while the bank still owes writes, so completion never collides.
  assign in_ready = (state_q == ST_RUN) && !((pos_q == 2'd3) && bank_full_q);

  always_comb begin
    accept     = in_valid && in_ready;
    last_drain = bank_full_q && wr_ready && (drain_q == K_LAST);

    s1_valid_d = accept;
    s1_kern_d  = kern_q;
    s1_pos_d   = pos_q;
    s1_pix_d   = pix_q;
    s1_sum_d   = SW'(bias_q[kern_q]);
    for (int c = 0; c < IN_CH; c++) begin
      s1_sum_d = s1_sum_d + SW'($signed(in_data[c*DW +: DW]));
    end

    sat_val    = DW'(sat_dw(64'(s1_sum_q), DW));
    relu_val   = sat_val[DW-1] ? '0 : sat_val;
    win_done_d = s1_valid_q && (s1_pos_q == 2'd3) && (s1_kern_q == K_LAST);
    win_pix_d  = s1_pix_q;

    bank_full_d = bank_full_q;
    bank_pix_d  = bank_pix_q;
    drain_d     = drain_q;
    bank_d      = bank_q;
    if (bank_full_q && wr_ready) begin
      if (drain_q == K_LAST) begin
        bank_full_d = 1'b0;
        drain_d     = '0;
      end else begin
        drain_d = drain_q + 1'b1;
      end
    end
    if (win_done_q) begin
      bank_full_d = 1'b1;
      bank_pix_d  = win_pix_q;
      drain_d     = '0;
      bank_d      = pool_res;
    end

    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    kern_d  = kern_q;
    pos_d   = pos_q;
    pix_d   = pix_q;
    bias_d  = bias_q;
    if (accept) begin
      if (kern_q == K_LAST) begin
        kern_d = '0;
        pos_d  = pos_q + 2'd1;
        if (pos_q == 2'd3) pix_d = (pix_q == P_LAST) ? '0 : pix_q + 1'b1;
      end else begin
        kern_d = kern_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bias_we) bias_d[bias_addr] = bias_wdata;
        if (start) begin
          state_d = ST_RUN;
          mode_d  = pool_mode;
          base_d  = out_base;
          kern_d  = '0;
          pos_d   = '0;
          pix_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept && (kern_q == K_LAST) && (pos_q == 2'd3) && (pix_q == P_LAST)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!s1_valid_q && !win_done_q && (!bank_full_q || last_drain)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  for (genvar k = 0; k < OUT_CH; k++) begin : g_pool
    pool_acc_unit #(.DW(DW)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (s1_valid_q && (s1_kern_q == KW'(k))),
      .load   (s1_pos_q == 2'd0),
      .mode   (mode_q),
      .val    (relu_val),
      .result (pool_res[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      base_q      <= '0;
      kern_q      <= '0;
      pos_q       <= '0;
      pix_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_kern_q   <= '0;
      s1_pos_q    <= '0;
      s1_pix_q    <= '0;
      win_done_q  <= 1'b0;
      win_pix_q   <= '0;
      bank_full_q <= 1'b0;
      bank_pix_q  <= '0;
      drain_q     <= '0;
      for (int k = 0; k < OUT_CH; k++) begin
        bias_q[k] <= '0;
        bank_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      kern_q      <= kern_d;
      pos_q       <= pos_d;
      pix_q       <= pix_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_kern_q   <= s1_kern_d;
      s1_pos_q    <= s1_pos_d;
      s1_pix_q    <= s1_pix_d;
      win_done_q  <= win_done_d;
      win_pix_q   <= win_pix_d;
      bank_full_q <= bank_full_d;
      bank_pix_q  <= bank_pix_d;
      drain_q     <= drain_d;
      bias_q      <= bias_d;
      bank_q      <= bank_d;
    end
  end

  assign wr_valid = bank_full_q;
  assign wr_data  = bank_q[drain_q];
  assign wr_addr  = base_q + ADDR_W'(drain_q) * ADDR_W'(MAP_SIZE) + ADDR_W'(bank_pix_q);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_pool_out_stage.sv
// tb/tb_conv_pool_out_stage.sv - scoreboard bench with a behavioural conv/pool reference model
module tb_conv_pool_out_stage;
  localparam int IN_CH = 6, OUT_CH = 16, DW = 16, OUT_PIXELS = 25, MAP_SIZE = 25, ADDR_W = 32;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic clk = 0, rst_n = 0, start = 0, pool_mode = 0, bias_we = 0, in_valid = 0, wr_ready = 1;
  logic [ADDR_W-1:0] out_base = '0;
  logic [3:0] bias_addr = '0;
  logic [DW-1:0] bias_wdata = '0;
  logic [IN_CH*DW-1:0] in_data = '0;
  logic in_ready, wr_valid, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  conv_pool_out_stage #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .DW(DW), .OUT_PIXELS(OUT_PIXELS),
                        .MAP_SIZE(MAP_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pool_mode(pool_mode), .out_base(out_base),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vals [OUT_PIXELS][4][OUT_CH][IN_CH];
  int bias_m [OUT_CH];
  typedef struct { logic [ADDR_W-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  int done_cnt = 0;
  int last_hs = -10;
  int bp_mode = 0, bp_hold = 0;
  bit bp_fired = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: per window position sum channels + bias, clamp, ReLU, then pool the four results.
  function automatic int exp_val(int p, int k, bit mode);
    int acc = 0;
    int s;
    for (int pos = 0; pos < 4; pos++) begin
      s = bias_m[k];
      for (int ch = 0; ch < IN_CH; ch++) s += vals[p][pos][k][ch];
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      if (s < 0) s = 0;
      if (!mode) acc = (pos == 0 || s > acc) ? s : acc;
      else acc += s;
    end
    return mode ? acc / 4 : acc;
  endfunction

  task automatic fill(input int pat);
    for (int p = 0; p < OUT_PIXELS; p++)
      for (int pos = 0; pos < 4; pos++)
        for (int k = 0; k < OUT_CH; k++)
          for (int ch = 0; ch < IN_CH; ch++)
            case (pat)
              0: vals[p][pos][k][ch] = 1;
              1: vals[p][pos][k][ch] = MAXV;
              2: vals[p][pos][k][ch] = -1;
              5: vals[p][pos][k][ch] = int'($urandom_range(0, 65535)) - 32768;
              6: vals[p][pos][k][ch] = int'($urandom_range(0, 5000)) - 2000;
              default: vals[p][pos][k][ch] = 0;
            endcase
    if (pat == 4) begin
      vals[0][0][0][0] = 3; vals[0][1][0][0] = 4; vals[0][2][0][0] = 5; vals[0][3][0][0] = 9;
    end
  endtask

  task automatic write_bias();
    for (int k = 0; k < OUT_CH; k++) begin
      @(negedge clk);
      bias_we = 1; bias_addr = 4'(k); bias_wdata = DW'(bias_m[k]);
    end
    @(negedge clk);
    bias_we = 0;
  endtask

  task automatic run_pass(input bit mode, input logic [ADDR_W-1:0] base, input int bpm,
                          input int abort_at, input bit expect_no_stall, input bit expect_stall);
    int stalls = 0, bi = 0, d0, w, t;
    wr_t e;
    bp_mode = bpm; bp_fired = 0; bp_hold = 0;
    for (int p = 0; p < OUT_PIXELS; p++)
      for (int k = 0; k < OUT_CH; k++) begin
        e.addr = base + ADDR_W'(k * MAP_SIZE + p);
        e.data = DW'(exp_val(p, k, mode));
        exp_q.push_back(e);
      end
    d0 = done_cnt;
    @(negedge clk);
    start = 1; pool_mode = mode; out_base = base;
    @(negedge clk);
    start = 0;
    check("busy_run", busy, 1);
    for (int p = 0; p < OUT_PIXELS; p++)
      for (int pos = 0; pos < 4; pos++)
        for (int k = 0; k < OUT_CH; k++) begin
          for (int ch = 0; ch < IN_CH; ch++) in_data[ch*DW +: DW] = DW'(vals[p][pos][k][ch]);
          in_valid = 1;
          if (bi == 20) begin
            start = 1; pool_mode = ~mode; out_base = base + 777;
            bias_we = 1; bias_addr = 0; bias_wdata = 16'h1234;
          end
          w = 0;
          while (!in_ready && w < 2000) begin
            stalls++;
            check("stall_pos", pos, 3);
            check("stall_bank_full", wr_valid, 1);
            @(negedge clk);
            w++;
          end
          if (w >= 2000) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready low for %0d cycles, required high", w);
          end
          @(negedge clk);
          start = 0; bias_we = 0;
          if (bi == abort_at) begin
            #2 rst_n = 0;
            #1;
            check("rst_wr_valid", wr_valid, 0); check("rst_in_ready", in_ready, 0);
            check("rst_busy", busy, 0); check("rst_done", done, 0);
            check("rst_wr_addr", wr_addr, 0); check("rst_wr_data", wr_data, 0);
            in_valid = 0;
            exp_q.delete();
            for (int kk = 0; kk < OUT_CH; kk++) bias_m[kk] = 0;
            @(negedge clk); @(negedge clk);
            rst_n = 1;
            repeat (5) begin
              @(negedge clk);
              check("post_rst_wr_valid", wr_valid, 0);
              check("post_rst_done", done, 0);
            end
            check("no_partial_done", done_cnt - d0, 0);
            return;
          end
          bi++;
        end
    in_valid = 0;
    if (expect_no_stall) check("no_stalls", stalls, 0);
    if (expect_stall) check("stalls_seen", stalls > 0, 1);
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("busy_idle", busy, 0);
    check("exp_drained", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: wr_ready = 1;
        1: wr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!bp_fired && wr_valid) begin bp_fired = 1; bp_hold = 100; end
          if (bp_hold > 0) begin wr_ready = 0; bp_hold--; end
          else wr_ready = 1;
        end
      endcase
    end
  end

  initial begin
    bit hold = 0;
    logic [ADDR_W-1:0] h_addr;
    logic [DW-1:0] h_data;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_valid", wr_valid, 1);
          check("hold_addr", wr_addr, h_addr);
          check("hold_data", wr_data, h_data);
        end
        hold = wr_valid && !wr_ready;
        h_addr = wr_addr; h_data = wr_data;
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
          last_hs = cyc;
        end
        if (done) begin
          done_cnt++;
          check("done_latency", cyc - last_hs, 1);
          check("done_queue_empty", exp_q.size(), 0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < OUT_CH; k++) bias_m[k] = 0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0); check("reset_wr_valid", wr_valid, 0);
    check("reset_done", done, 0); check("reset_busy", busy, 0);
    check("reset_wr_addr", wr_addr, 0); check("reset_wr_data", wr_data, 0);
    rst_n = 1;
    @(negedge clk);

    for (int k = 0; k < OUT_CH; k++) bias_m[k] = 2;
    write_bias(); fill(0); run_pass(0, 32'h1000, 0, -1, 1, 0);

    for (int k = 0; k < OUT_CH; k++) bias_m[k] = 100;
    write_bias(); fill(1); run_pass(0, 32'h2000, 1, -1, 0, 0);

    for (int k = 0; k < OUT_CH; k++) bias_m[k] = 0;
    write_bias(); fill(2); run_pass(1, 32'h3000, 0, -1, 1, 0);

    fill(4); run_pass(1, 32'h0, 0, -1, 1, 0);
    run_pass(0, 32'h0, 0, -1, 1, 0);

    for (int k = 0; k < OUT_CH; k++) bias_m[k] = k * 997 - 9000;
    write_bias(); fill(3); run_pass(0, 32'h4000, 0, -1, 1, 0);

    for (int k = 0; k < OUT_CH; k++) bias_m[k] = int'($urandom_range(0, 4000)) - 2000;
    write_bias(); fill(6); run_pass(0, 32'h5000, 2, -1, 0, 1);

    fill(5); run_pass(1, 32'hFFFF_FF80, 1, -1, 0, 0);

    fill(6); run_pass(0, 32'h6000, 0, 300, 0, 0);
    fill(6); run_pass(0, 32'h6000, 1, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
